aq_fadd_round_pack: RTL and testbench

- EX3→EX4 stage of the vector/scalar FP add pipe, directly downstream of the EX2/EX3 datapath stage.
- Consumes the EX3 exponent, sign, flags and unrounded mantissa for one lane.
- Applies carry normalisation, IEEE rounding, overflow/underflow detection and fflags generation.
- Packs and NaN-boxes the result into a 64-bit EX4 register, with a valid/stall/flush handshake to writeback.

---
 rtl/aq_fadd_round_pack.sv | 205 ++++++++++++++++++++
 tb/tb_aq_fadd_round_pack.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_fadd_round_pack.sv
// EX3->EX4 stage of the FP add pipe: carry normalisation, IEEE rounding,
// overflow/underflow detection, fflags generation and NaN-boxed packing
// into the EX4 result register with a valid/stall/flush handshake.
module aq_fadd_round_pack #(
  parameter logic [63:0] RST_DATA = 64'h0
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst_b,
  input  logic        ex3_vld,
  output logic        ex3_ready,
  input  logic        ex4_stall,
  input  logic        rtu_flush,
  input  logic        ex3_double,
  input  logic        ex3_single,
  input  logic        ex3_half,
  input  logic        ex3_bhalf,
  input  logic [2:0]  ex3_rm,
  input  logic        ex3_act_s,
  input  logic [10:0] ex3_org_e,
  input  logic [55:0] ex3_mant,
  input  logic        ex3_special_n_op_sel,
  input  logic        ex3_nv,
  input  logic        ex3_expt_mask,
  output logic        ex4_vld,
  output logic [63:0] ex4_result,
  output logic [4:0]  ex4_fflags
);

  localparam logic [2:0] RmRtz = 3'b001;
  localparam logic [2:0] RmRdn = 3'b010;
  localparam logic [2:0] RmRup = 3'b011;
  localparam logic [2:0] RmRmm = 3'b100;

  logic        ex4_vld_q, ex4_vld_d;
  logic [63:0] ex4_result_q, ex4_result_d;
  logic [4:0]  ex4_fflags_q, ex4_fflags_d;
  logic        pipedown;

  // Normalised mantissa: a set carry bit shifts everything right by one
  logic [54:0] norm_mant;
  logic        norm_lost;
  logic [11:0] norm_e;

  logic [5:0]  prec;
  logic [11:0] emax;
  logic [52:0] sig;
  logic        guard, sticky;
  logic [51:0] spec_frac;

  logic        inc, toward_zero, carry_out, hid_out, sig_ones, ovf, nx;
  logic [53:0] rounded;
  logic [1:0]  rounded_top;
  logic [52:0] ones_mask;
  logic [51:0] frac_mask;
  logic [11:0] exp_r;
  logic [10:0] exp_f;
  logic [51:0] frac_f;
  logic [4:0]  flags;

  assign norm_mant = ex3_mant[55] ? ex3_mant[55:1] : ex3_mant[54:0];
  assign norm_lost = ex3_mant[55] & ex3_mant[0];
  assign norm_e    = {1'b0, ex3_org_e} + {11'b0, ex3_mant[55]};

  // Per-format extraction: right-aligned significand plus guard/sticky
  always_comb begin
    prec      = 6'd0;
    emax      = 12'd0;
    sig       = '0;
    guard     = 1'b0;
    sticky    = 1'b0;
    spec_frac = '0;
    if (ex3_double) begin
      prec      = 6'd52;
      emax      = 12'd2047;
      sig       = norm_mant[54:2];
      guard     = norm_mant[1];
      sticky    = norm_mant[0] | norm_lost;
      spec_frac = ex3_mant[53:2];
    end else if (ex3_single) begin
      prec      = 6'd23;
      emax      = 12'd255;
      sig       = {29'b0, norm_mant[54:31]};
      guard     = norm_mant[30];
      sticky    = (|norm_mant[29:0]) | norm_lost;
      spec_frac = {29'b0, ex3_mant[53:31]};
    end else if (ex3_half) begin
      prec      = 6'd10;
      emax      = 12'd31;
      sig       = {42'b0, norm_mant[54:44]};
      guard     = norm_mant[43];
      sticky    = (|norm_mant[42:0]) | norm_lost;
      spec_frac = {42'b0, ex3_mant[53:44]};
    end else if (ex3_bhalf) begin
      prec      = 6'd7;
      emax      = 12'd255;
      sig       = {45'b0, norm_mant[54:47]};
      guard     = norm_mant[46];
      sticky    = (|norm_mant[45:0]) | norm_lost;
      spec_frac = {45'b0, ex3_mant[53:47]};
    end
  end

  // Rounding, overflow detection and final exponent/fraction/flags
  always_comb begin
    toward_zero = (ex3_rm == RmRtz) | ((ex3_rm == RmRdn) & ~ex3_act_s) |
                  ((ex3_rm == RmRup) & ex3_act_s);
    case (ex3_rm)
      RmRtz:   inc = 1'b0;
      RmRdn:   inc = ex3_act_s & (guard | sticky);
      RmRup:   inc = ~ex3_act_s & (guard | sticky);
      RmRmm:   inc = guard;
      default: inc = guard & (sticky | sig[0]);
    endcase
    rounded     = {1'b0, sig} + {53'b0, inc};
    rounded_top = 2'(rounded >> prec);
    carry_out   = rounded_top[1];
    hid_out     = rounded_top[0];
    ones_mask   = (53'h1 << (prec + 6'd1)) - 53'h1;
    frac_mask   = (52'h1 << prec) - 52'h1;
    sig_ones    = (sig == ones_mask);
    // A subnormal that rounds into the hidden bit becomes the smallest normal
    if ((norm_e == 12'd0) && hid_out) begin
      exp_r = 12'd1;
    end else begin
      exp_r = norm_e + {11'b0, carry_out};
    end
    // Truncating modes still flag overflow when the exact value exceeds max-finite
    ovf = (exp_r >= emax) |
          (toward_zero & (norm_e == emax - 12'd1) & sig_ones & (guard | sticky));
    nx  = guard | sticky | ovf;

    if (ex3_special_n_op_sel) begin
      exp_f  = ex3_org_e;
      frac_f = spec_frac;
      flags  = {ex3_nv, 4'b0};
    end else if (ovf) begin
      exp_f  = toward_zero ? 11'(emax - 12'd1) : emax[10:0];
      frac_f = toward_zero ? frac_mask : '0;
      flags  = {ex3_nv, 1'b0, 1'b1, 1'b0, 1'b1};
    end else begin
      exp_f  = exp_r[10:0];
      frac_f = rounded[51:0] & frac_mask;
      flags  = {ex3_nv, 1'b0, 1'b0, nx & (exp_r == 12'd0), nx};
    end
  end

  // Pack with NaN-boxing for narrow formats
  always_comb begin
    ex4_result_d = '0;
    ex4_fflags_d = flags;
    if (ex3_double) begin
      ex4_result_d = {ex3_act_s, exp_f, frac_f};
    end else if (ex3_single) begin
      ex4_result_d = {32'hFFFF_FFFF, ex3_act_s, exp_f[7:0], frac_f[22:0]};
    end else if (ex3_half) begin
      ex4_result_d = {48'hFFFF_FFFF_FFFF, ex3_act_s, exp_f[4:0], frac_f[9:0]};
    end else if (ex3_bhalf) begin
      ex4_result_d = {48'hFFFF_FFFF_FFFF, ex3_act_s, exp_f[7:0], frac_f[6:0]};
    end else begin
      ex4_fflags_d = '0;
    end
    if (ex3_expt_mask) begin
      ex4_fflags_d = '0;
    end
  end

  assign ex3_ready = ~ex4_vld_q | ~ex4_stall;
  assign pipedown  = ex3_vld & ex3_ready & ~rtu_flush;

  // Valid next state: flush beats everything, a stalled result is kept
  always_comb begin
    if (rtu_flush) begin
      ex4_vld_d = 1'b0;
    end else if (pipedown) begin
      ex4_vld_d = 1'b1;
    end else begin
      ex4_vld_d = ex4_stall & ex4_vld_q;
    end
  end

  // EX4 valid register
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      ex4_vld_q <= 1'b0;
    end else begin
      ex4_vld_q <= ex4_vld_d;
    end
  end

  // EX4 data registers load only on pipedown
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      ex4_result_q <= RST_DATA;
      ex4_fflags_q <= '0;
    end else if (pipedown) begin
      ex4_result_q <= ex4_result_d;
      ex4_fflags_q <= ex4_fflags_d;
    end
  end

  assign ex4_vld    = ex4_vld_q;
  assign ex4_result = ex4_result_q;
  assign ex4_fflags = ex4_fflags_q;

endmodule

// File: tb/tb_aq_fadd_round_pack.sv
// Bench for aq_fadd_round_pack: directed cases, handshake/reset scenarios and
// randomized operations checked against an arithmetic reference model.
module tb_aq_fadd_round_pack;

  logic        forever_cpuclk = 1'b0;
  logic        cpurst_b;
  logic        ex3_vld;
  logic        ex3_ready;
  logic        ex4_stall;
  logic        rtu_flush;
  logic        ex3_double, ex3_single, ex3_half, ex3_bhalf;
  logic [2:0]  ex3_rm;
  logic        ex3_act_s;
  logic [10:0] ex3_org_e;
  logic [55:0] ex3_mant;
  logic        ex3_special_n_op_sel;
  logic        ex3_nv;
  logic        ex3_expt_mask;
  logic        ex4_vld;
  logic [63:0] ex4_result;
  logic [4:0]  ex4_fflags;

  int checks   = 0;
  int failures = 0;

  aq_fadd_round_pack #(.RST_DATA(64'h0)) dut (
    .forever_cpuclk       (forever_cpuclk),
    .cpurst_b             (cpurst_b),
    .ex3_vld              (ex3_vld),
    .ex3_ready            (ex3_ready),
    .ex4_stall            (ex4_stall),
    .rtu_flush            (rtu_flush),
    .ex3_double           (ex3_double),
    .ex3_single           (ex3_single),
    .ex3_half             (ex3_half),
    .ex3_bhalf            (ex3_bhalf),
    .ex3_rm               (ex3_rm),
    .ex3_act_s            (ex3_act_s),
    .ex3_org_e            (ex3_org_e),
    .ex3_mant             (ex3_mant),
    .ex3_special_n_op_sel (ex3_special_n_op_sel),
    .ex3_nv               (ex3_nv),
    .ex3_expt_mask        (ex3_expt_mask),
    .ex4_vld              (ex4_vld),
    .ex4_result           (ex4_result),
    .ex4_fflags           (ex4_fflags)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // fmt: 0 double, 1 single, 2 half, 3 bhalf, other none
  task automatic set_in(input int fmt, input logic [2:0] rm, input logic s,
                        input logic [10:0] e, input logic [55:0] m, input logic spec,
                        input logic nv, input logic mask);
    ex3_double = (fmt == 0);
    ex3_single = (fmt == 1);
    ex3_half   = (fmt == 2);
    ex3_bhalf  = (fmt == 3);
    ex3_rm = rm;
    ex3_act_s = s;
    ex3_org_e = e;
    ex3_mant = m;
    ex3_special_n_op_sel = spec;
    ex3_nv = nv;
    ex3_expt_mask = mask;
  endtask

  task automatic run_op(input string tag, input logic [63:0] exp_res, input logic [4:0] exp_fl);
    ex3_vld = 1'b1;
    @(posedge forever_cpuclk); #1;
    ex3_vld = 1'b0;
    check({tag, "_vld"}, 64'(ex4_vld), 64'd1);
    check({tag, "_res"}, ex4_result, exp_res);
    check({tag, "_ff"}, 64'(ex4_fflags), 64'(exp_fl));
  endtask

  // Reference: treat the mantissa as an integer, keep P+1 significant bits
  // by integer division and round from the remainder.
  function automatic void ref_model(input int fmt, input logic [2:0] rm, input logic s,
      input logic [10:0] e, input logic [55:0] m, input logic spec, input logic nv,
      input logic mask, output logic [63:0] res, output logic [4:0] fl);
    int p, k;
    longint unsigned emax, one, mm, q, q_exact, r, half, en, er, frac, limit;
    logic up, nx, of, tz;
    one = 64'd1;
    res = '0;
    fl = '0;
    p = 0;
    emax = 0;
    case (fmt)
      0: begin p = 52; emax = 2047; end
      1: begin p = 23; emax = 255; end
      2: begin p = 10; emax = 31; end
      3: begin p = 7; emax = 255; end
      default: return;
    endcase
    mm = 64'(m);
    if (spec) begin
      er = 64'(e);
      frac = (mm >> (54 - p)) & ((one << p) - 1);
      fl = {nv, 4'b0};
    end else begin
      k = 54 - p + (m[55] ? 1 : 0);
      en = 64'(e) + (m[55] ? 64'd1 : 64'd0);
      q_exact = mm >> k;
      r = mm & ((one << k) - 1);
      half = one << (k - 1);
      tz = (rm == 3'd1) || (rm == 3'd2 && !s) || (rm == 3'd3 && s);
      case (rm)
        3'd1: up = 1'b0;
        3'd2: up = s && (r != 0);
        3'd3: up = !s && (r != 0);
        3'd4: up = (r >= half);
        default: up = (r > half) || (r == half && q_exact[0]);
      endcase
      q = q_exact + (up ? 64'd1 : 64'd0);
      er = en;
      if (q == (one << (p + 1))) begin
        q = one << p;
        er = er + 1;
      end
      if (er == 0 && q >= (one << p)) er = 1;
      nx = (r != 0);
      limit = (one << (p + 1)) - 1;
      of = (er >= emax) || (tz && en == emax - 1 && q_exact == limit && nx);
      if (of) begin
        nx = 1'b1;
        if (tz) begin
          er = emax - 1;
          frac = (one << p) - 1;
        end else begin
          er = emax;
          frac = 0;
        end
      end else begin
        frac = q & ((one << p) - 1);
      end
      fl = {nv, 1'b0, of, nx && (er == 0), nx};
    end
    if (mask) fl = '0;
    er = er & emax;
    case (fmt)
      0: res = {s, er[10:0], frac[51:0]};
      1: res = {32'hFFFF_FFFF, s, er[7:0], frac[22:0]};
      2: res = {48'hFFFF_FFFF_FFFF, s, er[4:0], frac[9:0]};
      default: res = {48'hFFFF_FFFF_FFFF, s, er[7:0], frac[6:0]};
    endcase
  endfunction

  logic [55:0] one56;
  logic [55:0] m_t1, m_t3, m_sub;
  int          r_fmt, r_cls, r_p;
  int unsigned r_emx;
  logic [2:0]  r_rm;
  logic        r_s, r_spec, r_nv, r_mask;
  logic [10:0] r_e;
  logic [55:0] r_m, r_ones;
  logic [63:0] r64, e_res;
  logic [4:0]  e_fl;

  initial begin
    one56 = 56'd1;
    m_t1  = (one56 << 54) | (one56 << 30);
    m_t3  = (one56 << 54) | (((one56 << 23) - 56'd1) << 31) | (one56 << 30);
    m_sub = (((one56 << 23) - 56'd1) << 31) | (one56 << 30);

    cpurst_b = 1'b0;
    ex3_vld = 1'b0;
    ex4_stall = 1'b0;
    rtu_flush = 1'b0;
    set_in(4, 3'd0, 1'b0, 11'd0, 56'd0, 1'b0, 1'b0, 1'b0);
    #12;
    check("rst_vld", 64'(ex4_vld), 64'd0);
    check("rst_res", ex4_result, 64'h0);
    check("rst_ff", 64'(ex4_fflags), 64'd0);
    check("rst_ready", 64'(ex3_ready), 64'd1);
    cpurst_b = 1'b1;
    @(posedge forever_cpuclk); #1;

    // Directed cases
    set_in(1, 3'd0, 1'b0, 11'h7F, m_t1, 1'b0, 1'b0, 1'b0);
    run_op("s_rne_tie_even", 64'hFFFF_FFFF_3F80_0000, 5'b00001);
    set_in(0, 3'd0, 1'b0, 11'h3FF, one56 << 55, 1'b0, 1'b0, 1'b0);
    run_op("d_carry", 64'h4000_0000_0000_0000, 5'b00000);
    set_in(1, 3'd0, 1'b0, 11'hFE, m_t3, 1'b0, 1'b0, 1'b0);
    run_op("s_ovf_rne", 64'hFFFF_FFFF_7F80_0000, 5'b00101);
    set_in(1, 3'd1, 1'b0, 11'hFE, m_t3, 1'b0, 1'b0, 1'b0);
    run_op("s_ovf_rtz", 64'hFFFF_FFFF_7F7F_FFFF, 5'b00101);
    set_in(1, 3'd2, 1'b1, 11'hFE, m_t3, 1'b0, 1'b0, 1'b0);
    run_op("s_ovf_rdn_neg", 64'hFFFF_FFFF_FF80_0000, 5'b00101);
    set_in(2, 3'd0, 1'b0, 11'h1F, one56 << 53, 1'b1, 1'b1, 1'b0);
    run_op("h_special", 64'hFFFF_FFFF_FFFF_7E00, 5'b10000);
    set_in(2, 3'd0, 1'b0, 11'h1F, one56 << 53, 1'b1, 1'b1, 1'b1);
    run_op("h_special_mask", 64'hFFFF_FFFF_FFFF_7E00, 5'b00000);
    set_in(1, 3'd0, 1'b0, 11'h0, m_sub, 1'b0, 1'b0, 1'b0);
    run_op("s_sub_to_norm", 64'hFFFF_FFFF_0080_0000, 5'b00001);
    set_in(4, 3'd0, 1'b1, 11'h7F, m_t1, 1'b0, 1'b1, 1'b0);
    run_op("no_fmt", 64'h0, 5'b00000);
    @(posedge forever_cpuclk); #1;
    check("idle_vld_clear", 64'(ex4_vld), 64'd0);

    // Stall holds EX4, then flush kills it
    set_in(1, 3'd0, 1'b0, 11'h7F, m_t1, 1'b0, 1'b0, 1'b0);
    run_op("stall_a", 64'hFFFF_FFFF_3F80_0000, 5'b00001);
    ex4_stall = 1'b1;
    set_in(0, 3'd0, 1'b0, 11'h3FF, one56 << 55, 1'b0, 1'b0, 1'b0);
    ex3_vld = 1'b1;
    #1;
    check("stall_ready0", 64'(ex3_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge forever_cpuclk); #1;
      check($sformatf("stall_vld%0d", i), 64'(ex4_vld), 64'd1);
      check($sformatf("stall_res%0d", i), ex4_result, 64'hFFFF_FFFF_3F80_0000);
      check($sformatf("stall_ff%0d", i), 64'(ex4_fflags), 64'd1);
      check($sformatf("stall_rdy%0d", i), 64'(ex3_ready), 64'd0);
    end
    rtu_flush = 1'b1;
    @(posedge forever_cpuclk); #1;
    check("flush_vld", 64'(ex4_vld), 64'd0);
    check("flush_res_hold", ex4_result, 64'hFFFF_FFFF_3F80_0000);
    @(posedge forever_cpuclk); #1;
    check("flush_blocks_pd", 64'(ex4_vld), 64'd0);
    rtu_flush = 1'b0;
    ex4_stall = 1'b0;
    @(posedge forever_cpuclk); #1;
    check("post_flush_vld", 64'(ex4_vld), 64'd1);
    check("post_flush_res", ex4_result, 64'h4000_0000_0000_0000);
    ex3_vld = 1'b0;

    // Asynchronous reset while EX4 holds a result
    set_in(1, 3'd0, 1'b0, 11'hFE, m_t3, 1'b0, 1'b0, 1'b0);
    run_op("pre_rst", 64'hFFFF_FFFF_7F80_0000, 5'b00101);
    #2;
    cpurst_b = 1'b0;
    #1;
    check("arst_vld", 64'(ex4_vld), 64'd0);
    check("arst_res", ex4_result, 64'h0);
    check("arst_ff", 64'(ex4_fflags), 64'd0);
    set_in(0, 3'd0, 1'b0, 11'h3FF, one56 << 55, 1'b0, 1'b0, 1'b0);
    ex3_vld = 1'b1;
    @(posedge forever_cpuclk); #1;
    check("arst_no_pd", 64'(ex4_vld), 64'd0);
    check("arst_no_pd_res", ex4_result, 64'h0);
    #2;
    cpurst_b = 1'b1;
    @(posedge forever_cpuclk); #1;
    check("rel_vld", 64'(ex4_vld), 64'd1);
    check("rel_res", ex4_result, 64'h4000_0000_0000_0000);
    ex3_vld = 1'b0;
    @(posedge forever_cpuclk); #1;

    // Randomized operations against the reference model
    for (int i = 0; i < 400; i++) begin
      r_fmt = ($urandom_range(0, 19) == 0) ? 4 : int'($urandom_range(0, 3));
      case (r_fmt)
        0: begin r_p = 52; r_emx = 2047; end
        1: begin r_p = 23; r_emx = 255; end
        2: begin r_p = 10; r_emx = 31; end
        default: begin r_p = 7; r_emx = 255; end
      endcase
      r_cls = int'($urandom_range(0, 4));
      r64 = {$urandom, $urandom};
      r_rm = 3'($urandom_range(0, 7));
      r_s = 1'($urandom);
      case (r_cls)
        0: begin r_m = {2'b01, r64[53:0]}; r_e = 11'($urandom_range(1, r_emx - 1)); end
        1: begin r_m = {1'b1, r64[54:0]}; r_e = 11'($urandom_range(1, r_emx - 1)); end
        2: begin r_m = {2'b00, r64[53:0]}; r_e = 11'd0; end
        3: begin
          r_ones = ((one56 << r_p) - 56'd1) << (54 - r_p);
          r_m = {2'b01, r64[53:0]} | r_ones;
          r_e = 11'(r_emx - 1);
        end
        default: begin
          r_ones = ((one56 << (r_p + 1)) - 56'd1) << (55 - r_p);
          r_m = {1'b1, r64[54:0]} | r_ones;
          r_e = 11'(r_emx - 2);
        end
      endcase
      r_spec = ($urandom_range(0, 7) == 0);
      if (r_spec) r_e = 11'($urandom_range(0, r_emx));
      r_nv = ($urandom_range(0, 3) == 0);
      r_mask = ($urandom_range(0, 7) == 0);
      set_in(r_fmt, r_rm, r_s, r_e, r_m, r_spec, r_nv, r_mask);
      ref_model(r_fmt, r_rm, r_s, r_e, r_m, r_spec, r_nv, r_mask, e_res, e_fl);
      run_op($sformatf("rnd%0d", i), e_res, e_fl);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge forever_cpuclk); #1;
        check($sformatf("rnd%0d_idle", i), 64'(ex4_vld), 64'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
